// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched micro-ops, snoops the CDB,
// issues one operand-ready micro-op per cycle into a registered slot.
// Ports: clk_i/reset_i (async, active-low), flush_i (sync squash),
//   dispatch* (valid/ready + op fields), cdb* (result broadcast),
//   reservationStation*_o/readyRS_o (issue slot), stallRS_i (hold slot).
module alu_reservation_station #(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int RSsize     = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  dispatchValid_i,
  output logic                  dispatchReady_o,
  input  logic [9:0]            dispatchCommands_i,
  input  logic [ROBsizeLog-1:0] dispatchTag_i,
  input  logic [63:0]           dispatchVal1_i,
  input  logic [63:0]           dispatchVal2_i,
  input  logic                  dispatchRdy1_i,
  input  logic                  dispatchRdy2_i,
  input  logic [ROBsizeLog-1:0] dispatchSrc1_i,
  input  logic [ROBsizeLog-1:0] dispatchSrc2_i,
  input  logic                  cdbValid_i,
  input  logic [ROBsizeLog-1:0] cdbTag_i,
  input  logic [63:0]           cdbVal_i,
  output logic [63:0]           reservationStationVal1_o,
  output logic [63:0]           reservationStationVal2_o,
  output logic [9:0]            reservationStationCommands_o,
  output logic [ROBsizeLog-1:0] reservationStationTag_o,
  output logic                  readyRS_o,
  input  logic                  stallRS_i
);

  localparam int IW = $clog2(RSsize);

  typedef logic [ROBsizeLog-1:0] tag_t;

  // Station entries
  logic [RSsize-1:0] busy_q, busy_d;
  logic [RSsize-1:0] rdy1_q, rdy1_d;
  logic [RSsize-1:0] rdy2_q, rdy2_d;
  logic [9:0]        cmd_q  [RSsize];
  logic [9:0]        cmd_d  [RSsize];
  tag_t              tag_q  [RSsize];
  tag_t              tag_d  [RSsize];
  tag_t              src1_q [RSsize];
  tag_t              src1_d [RSsize];
  tag_t              src2_q [RSsize];
  tag_t              src2_d [RSsize];
  logic [63:0]       val1_q [RSsize];
  logic [63:0]       val1_d [RSsize];
  logic [63:0]       val2_q [RSsize];
  logic [63:0]       val2_d [RSsize];

  // Issue slot
  logic        slot_vld_q,  slot_vld_d;
  logic [63:0] slot_val1_q, slot_val1_d;
  logic [63:0] slot_val2_q, slot_val2_d;
  logic [9:0]  slot_cmd_q,  slot_cmd_d;
  tag_t        slot_tag_q,  slot_tag_d;

  logic [RSsize-1:0] elig;
  logic              free_found;
  logic              elig_found;
  logic [IW-1:0]     free_idx;
  logic [IW-1:0]     elig_idx;
  logic              slot_load;
  logic              issue_go;
  logic              disp_go;
  logic              byp1;
  logic              byp2;

  // Eligibility uses registered ready bits only; a same-cycle
  // wakeup becomes eligible one cycle later.
  assign elig = busy_q & rdy1_q & rdy2_q;

  // Full only when every entry is busy in registered state, so an
  // entry freed by this cycle's issue is reusable next cycle.
  assign dispatchReady_o = ~&busy_q;

  assign slot_load = ~slot_vld_q | ~stallRS_i;
  assign issue_go  = slot_load & elig_found;
  assign disp_go   = dispatchValid_i & dispatchReady_o & ~flush_i;

  assign byp1 = ~dispatchRdy1_i & cdbValid_i &
                (cdbTag_i == dispatchSrc1_i);
  assign byp2 = ~dispatchRdy2_i & cdbValid_i &
                (cdbTag_i == dispatchSrc2_i);

  // Lowest-index free and eligible entries: scan downwards so the
  // last hit wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    elig_found = 1'b0;
    elig_idx   = '0;
    for (int i = RSsize - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (elig[i]) begin
        elig_found = 1'b1;
        elig_idx   = IW'(i);
      end
    end
  end

  // Entry next state
  always_comb begin
    busy_d = busy_q;
    rdy1_d = rdy1_q;
    rdy2_d = rdy2_q;
    cmd_d  = cmd_q;
    tag_d  = tag_q;
    src1_d = src1_q;
    src2_d = src2_q;
    val1_d = val1_q;
    val2_d = val2_q;

    for (int i = 0; i < RSsize; i++) begin
      if (busy_q[i] && !rdy1_q[i] && cdbValid_i &&
          src1_q[i] == cdbTag_i) begin
        rdy1_d[i] = 1'b1;
        val1_d[i] = cdbVal_i;
      end
      if (busy_q[i] && !rdy2_q[i] && cdbValid_i &&
          src2_q[i] == cdbTag_i) begin
        rdy2_d[i] = 1'b1;
        val2_d[i] = cdbVal_i;
      end
    end

    if (issue_go) begin
      busy_d[elig_idx] = 1'b0;
    end

    // free_idx never equals elig_idx: one is idle, one is busy.
    if (disp_go && free_found) begin
      busy_d[free_idx] = 1'b1;
      cmd_d[free_idx]  = dispatchCommands_i;
      tag_d[free_idx]  = dispatchTag_i;
      src1_d[free_idx] = dispatchSrc1_i;
      src2_d[free_idx] = dispatchSrc2_i;
      rdy1_d[free_idx] = dispatchRdy1_i | byp1;
      rdy2_d[free_idx] = dispatchRdy2_i | byp2;
      val1_d[free_idx] = byp1 ? cdbVal_i : dispatchVal1_i;
      val2_d[free_idx] = byp2 ? cdbVal_i : dispatchVal2_i;
    end

    if (flush_i) begin
      busy_d = '0;
    end
  end

  // Issue slot next state
  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_val1_d = slot_val1_q;
    slot_val2_d = slot_val2_q;
    slot_cmd_d  = slot_cmd_q;
    slot_tag_d  = slot_tag_q;

    if (slot_load) begin
      slot_vld_d = elig_found;
      if (elig_found) begin
        slot_val1_d = val1_q[elig_idx];
        slot_val2_d = val2_q[elig_idx];
        slot_cmd_d  = cmd_q[elig_idx];
        slot_tag_d  = tag_q[elig_idx];
      end
    end

    if (flush_i) begin
      slot_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      busy_q <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
      for (int i = 0; i < RSsize; i++) begin
        cmd_q[i]  <= '0;
        tag_q[i]  <= '0;
        src1_q[i] <= '0;
        src2_q[i] <= '0;
        val1_q[i] <= '0;
        val2_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      rdy1_q <= rdy1_d;
      rdy2_q <= rdy2_d;
      cmd_q  <= cmd_d;
      tag_q  <= tag_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
      val1_q <= val1_d;
      val2_q <= val2_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      slot_vld_q  <= 1'b0;
      slot_val1_q <= '0;
      slot_val2_q <= '0;
      slot_cmd_q  <= '0;
      slot_tag_q  <= '0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_val1_q <= slot_val1_d;
      slot_val2_q <= slot_val2_d;
      slot_cmd_q  <= slot_cmd_d;
      slot_tag_q  <= slot_tag_d;
    end
  end

  assign readyRS_o                    = slot_vld_q;
  assign reservationStationVal1_o     = slot_val1_q;
  assign reservationStationVal2_o     = slot_val2_q;
  assign reservationStationCommands_o = slot_cmd_q;
  assign reservationStationTag_o      = slot_tag_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed scenarios
// plus random traffic against a behavioural station model.
module tb_alu_reservation_station;

  localparam int TW = 6;
  localparam int NE = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          d_valid;
  logic          d_ready;
  logic [9:0]    d_cmd;
  logic [TW-1:0] d_tag;
  logic [63:0]   d_v1, d_v2;
  logic          d_r1, d_r2;
  logic [TW-1:0] d_s1, d_s2;
  logic          c_valid;
  logic [TW-1:0] c_tag;
  logic [63:0]   c_val;
  logic [63:0]   o_v1, o_v2;
  logic [9:0]    o_cmd;
  logic [TW-1:0] o_tag;
  logic          o_rdy;
  logic          stall;

  int n_vec = 0;
  int n_err = 0;

  alu_reservation_station dut (
    .clk_i                        (clk),
    .reset_i                      (rst_n),
    .flush_i                      (flush),
    .dispatchValid_i              (d_valid),
    .dispatchReady_o              (d_ready),
    .dispatchCommands_i           (d_cmd),
    .dispatchTag_i                (d_tag),
    .dispatchVal1_i               (d_v1),
    .dispatchVal2_i               (d_v2),
    .dispatchRdy1_i               (d_r1),
    .dispatchRdy2_i               (d_r2),
    .dispatchSrc1_i               (d_s1),
    .dispatchSrc2_i               (d_s2),
    .cdbValid_i                   (c_valid),
    .cdbTag_i                     (c_tag),
    .cdbVal_i                     (c_val),
    .reservationStationVal1_o     (o_v1),
    .reservationStationVal2_o     (o_v2),
    .reservationStationCommands_o (o_cmd),
    .reservationStationTag_o      (o_tag),
    .readyRS_o                    (o_rdy),
    .stallRS_i                    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Behavioural model: a bag of waiting ops plus one output slot.
  typedef struct {
    bit          busy;
    bit [9:0]    cmd;
    bit [TW-1:0] tag;
    bit          r1, r2;
    bit [TW-1:0] s1, s2;
    bit [63:0]   v1, v2;
  } ent_t;

  ent_t        me [NE];
  bit          mv;
  bit [63:0]   mv1, mv2;
  bit [9:0]    mcmd;
  bit [TW-1:0] mtag;

  task automatic model_reset();
    for (int i = 0; i < NE; i++) me[i].busy = 0;
    mv = 0; mv1 = 0; mv2 = 0; mcmd = 0; mtag = 0;
  endtask

  task automatic model_step();
    ent_t n [NE];
    int fr, el;
    bit ld;
    n = me;
    fr = -1; el = -1;
    for (int i = 0; i < NE; i++) begin
      if (!me[i].busy && fr < 0) fr = i;
      if (me[i].busy && me[i].r1 && me[i].r2 && el < 0) el = i;
    end
    for (int i = 0; i < NE; i++) begin
      if (n[i].busy && c_valid) begin
        if (!n[i].r1 && n[i].s1 == c_tag) begin
          n[i].r1 = 1; n[i].v1 = c_val;
        end
        if (!n[i].r2 && n[i].s2 == c_tag) begin
          n[i].r2 = 1; n[i].v2 = c_val;
        end
      end
    end
    ld = !mv || !stall;
    if (ld) begin
      if (el >= 0) begin
        mv = 1; mv1 = me[el].v1; mv2 = me[el].v2;
        mcmd = me[el].cmd; mtag = me[el].tag;
        n[el].busy = 0;
      end else begin
        mv = 0;
      end
    end
    if (d_valid && fr >= 0) begin
      n[fr].busy = 1; n[fr].cmd = d_cmd; n[fr].tag = d_tag;
      n[fr].s1 = d_s1; n[fr].s2 = d_s2;
      n[fr].r1 = d_r1; n[fr].v1 = d_v1;
      n[fr].r2 = d_r2; n[fr].v2 = d_v2;
      if (!d_r1 && c_valid && c_tag == d_s1) begin
        n[fr].r1 = 1; n[fr].v1 = c_val;
      end
      if (!d_r2 && c_valid && c_tag == d_s2) begin
        n[fr].r2 = 1; n[fr].v2 = c_val;
      end
    end
    if (flush) begin
      for (int i = 0; i < NE; i++) n[i].busy = 0;
      mv = 0;
    end
    me = n;
  endtask

  function automatic bit model_full();
    bit f = 1;
    for (int i = 0; i < NE; i++) if (!me[i].busy) f = 0;
    return f;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; d_valid = 0; d_cmd = 0; d_tag = 0;
    d_v1 = 0; d_v2 = 0; d_r1 = 0; d_r2 = 0; d_s1 = 0; d_s2 = 0;
    c_valid = 0; c_tag = 0; c_val = 0;
  endtask

  task automatic set_disp(input bit [TW-1:0] tag, input bit [9:0] cmd,
                          input bit r1, input bit [63:0] v1,
                          input bit [TW-1:0] s1,
                          input bit r2, input bit [63:0] v2,
                          input bit [TW-1:0] s2);
    d_valid = 1; d_tag = tag; d_cmd = cmd;
    d_r1 = r1; d_v1 = v1; d_s1 = s1;
    d_r2 = r2; d_v2 = v2; d_s2 = s2;
  endtask

  task automatic test_reset();
    idle_inputs();
    stall = 0;
    rst_n = 0;
    model_reset();
    #1;
    n_vec++;
    if (o_rdy !== 1'b0) begin
      n_err++; $display("FAIL reset_ready got %0b want 0", o_rdy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
    n_vec++;
    if (d_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_dready got %0b want 1", d_ready);
    end
    n_vec++;
    if ({o_v1, o_v2, o_cmd, o_tag} !== '0) begin
      n_err++;
      $display("FAIL reset_data got %h/%h/%h/%h want 0",
               o_v1, o_v2, o_cmd, o_tag);
    end
  endtask

  task automatic test_basic();
    set_disp(3, 10, 1, 15, 0, 1, 3, 0);
    tick();
    idle_inputs();
    n_vec++;
    if (o_rdy !== 1'b0) begin
      n_err++; $display("FAIL basic_early got %0b want 0", o_rdy);
    end
    tick();
    n_vec++;
    if (o_rdy !== 1'b1 || o_v1 !== 64'd15 || o_v2 !== 64'd3 ||
        o_tag !== 6'd3 || o_cmd !== 10'd10) begin
      n_err++;
      $display("FAIL basic_issue got r%0b %0d/%0d t%0d c%0d want r1 15/3 t3 c10",
               o_rdy, o_v1, o_v2, o_tag, o_cmd);
    end
    tick();
    n_vec++;
    if (o_rdy !== 1'b0) begin
      n_err++; $display("FAIL basic_clear got %0b want 0", o_rdy);
    end
  endtask

  task automatic test_wakeup();
    set_disp(5, 1, 1, 64'h11, 0, 0, 0, 7);
    tick();
    idle_inputs();
    c_valid = 1; c_tag = 6; c_val = 64'h66;
    tick();
    n_vec++;
    if (o_rdy !== 1'b0) begin
      n_err++; $display("FAIL wake_tag6a got %0b want 0", o_rdy);
    end
    c_tag = 7; c_val = 64'h55;
    tick();
    c_valid = 0;
    n_vec++;
    if (o_rdy !== 1'b0) begin
      n_err++; $display("FAIL wake_tag6b got %0b want 0", o_rdy);
    end
    tick();
    n_vec++;
    if (o_rdy !== 1'b1 || o_v2 !== 64'h55 || o_v1 !== 64'h11 ||
        o_tag !== 6'd5) begin
      n_err++;
      $display("FAIL wake_issue got r%0b %h/%h t%0d want r1 11/55 t5",
               o_rdy, o_v1, o_v2, o_tag);
    end
    tick();
  endtask

  task automatic test_bypass();
    set_disp(8, 2, 0, 0, 9, 1, 64'h22, 0);
    c_valid = 1; c_tag = 9; c_val = 64'hAA;
    tick();
    idle_inputs();
    n_vec++;
    if (o_rdy !== 1'b0) begin
      n_err++; $display("FAIL byp_early got %0b want 0", o_rdy);
    end
    tick();
    n_vec++;
    if (o_rdy !== 1'b1 || o_v1 !== 64'hAA || o_v2 !== 64'h22 ||
        o_tag !== 6'd8) begin
      n_err++;
      $display("FAIL byp_issue got r%0b %h/%h t%0d want r1 aa/22 t8",
               o_rdy, o_v1, o_v2, o_tag);
    end
    tick();
  endtask

  task automatic test_full_stall();
    bit [TW-1:0] order [4];
    order[0] = 12; order[1] = 11; order[2] = 13; order[3] = 14;
    stall = 1;
    for (int k = 0; k < 5; k++) begin
      set_disp(TW'(10 + k), 10'(k), 1, 64'(3 * k + 1), 0,
               1, 64'(3 * k + 2), 0);
      tick();
    end
    idle_inputs();
    n_vec++;
    if (d_ready !== 1'b0) begin
      n_err++; $display("FAIL full_dready got %0b want 0", d_ready);
    end
    set_disp(15, 9, 1, 64'h99, 0, 1, 64'h98, 0);
    tick();
    idle_inputs();
    tick();
    n_vec++;
    if (d_ready !== 1'b0 || o_rdy !== 1'b1 || o_tag !== 6'd10 ||
        o_v1 !== 64'd1 || o_v2 !== 64'd2) begin
      n_err++;
      $display("FAIL full_frozen got dr%0b r%0b t%0d %0d/%0d want dr0 r1 t10 1/2",
               d_ready, o_rdy, o_tag, o_v1, o_v2);
    end
    stall = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (o_rdy !== 1'b1 || o_tag !== order[k] || o_tag !== mtag ||
          o_v1 !== mv1 || o_v2 !== mv2) begin
        n_err++;
        $display("FAIL drain_%0d got r%0b t%0d want r1 t%0d",
                 k, o_rdy, o_tag, order[k]);
      end
    end
    tick();
    n_vec++;
    if (o_rdy !== 1'b0 || d_ready !== 1'b1) begin
      n_err++;
      $display("FAIL drain_end got r%0b dr%0b want r0 dr1", o_rdy, d_ready);
    end
  endtask

  task automatic test_out_of_order();
    set_disp(20, 3, 0, 0, 1, 1, 64'h20, 0);
    tick();
    set_disp(21, 4, 0, 0, 2, 1, 64'h21, 0);
    tick();
    idle_inputs();
    c_valid = 1; c_tag = 2; c_val = 64'h222;
    tick();
    c_valid = 0;
    n_vec++;
    if (o_rdy !== 1'b0) begin
      n_err++; $display("FAIL ooo_early got %0b want 0", o_rdy);
    end
    tick();
    n_vec++;
    if (o_rdy !== 1'b1 || o_tag !== 6'd21 || o_v1 !== 64'h222) begin
      n_err++;
      $display("FAIL ooo_first got r%0b t%0d %h want r1 t21 222",
               o_rdy, o_tag, o_v1);
    end
    c_valid = 1; c_tag = 1; c_val = 64'h111;
    tick();
    c_valid = 0;
    tick();
    n_vec++;
    if (o_rdy !== 1'b1 || o_tag !== 6'd20 || o_v1 !== 64'h111 ||
        o_v2 !== 64'h20) begin
      n_err++;
      $display("FAIL ooo_second got r%0b t%0d %h want r1 t20 111",
               o_rdy, o_tag, o_v1);
    end
    tick();
  endtask

  task automatic test_flush_reset();
    stall = 1;
    for (int k = 0; k < 4; k++) begin
      set_disp(TW'(24 + k), 5, 1, 64'(k), 0, 1, 64'(k), 0);
      tick();
    end
    n_vec++;
    if (o_rdy !== 1'b1 || d_ready !== 1'b1 || o_tag !== 6'd24) begin
      n_err++;
      $display("FAIL flush_pre got r%0b dr%0b t%0d want r1 dr1 t24",
               o_rdy, d_ready, o_tag);
    end
    set_disp(28, 5, 1, 1, 0, 1, 1, 0);
    flush = 1;
    tick();
    idle_inputs();
    n_vec++;
    if (o_rdy !== 1'b0 || d_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_post got r%0b dr%0b want r0 dr1", o_rdy, d_ready);
    end
    stall = 0;
    tick();
    tick();
    n_vec++;
    if (o_rdy !== 1'b0) begin
      n_err++; $display("FAIL flush_drop got %0b want 0", o_rdy);
    end
    stall = 1;
    set_disp(29, 7, 1, 64'h77, 0, 1, 64'h78, 0);
    tick();
    idle_inputs();
    tick();
    n_vec++;
    if (o_rdy !== 1'b1 || o_tag !== 6'd29) begin
      n_err++;
      $display("FAIL rst_pre got r%0b t%0d want r1 t29", o_rdy, o_tag);
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    n_vec++;
    if (o_rdy !== 1'b0 || {o_v1, o_v2, o_cmd, o_tag} !== '0) begin
      n_err++;
      $display("FAIL rst_mid got r%0b %h/%h c%0d t%0d want all 0",
               o_rdy, o_v1, o_v2, o_cmd, o_tag);
    end
    @(posedge clk);
    #1 rst_n = 1;
    stall = 0;
    #1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      d_valid = ($urandom % 2) == 1;
      d_tag   = TW'($urandom_range(0, 31));
      d_cmd   = 10'($urandom);
      d_r1    = ($urandom % 3) != 0;
      d_r2    = ($urandom % 3) != 0;
      d_v1    = {$urandom, $urandom};
      d_v2    = {$urandom, $urandom};
      d_s1    = TW'($urandom_range(0, 5));
      d_s2    = TW'($urandom_range(0, 5));
      c_valid = ($urandom % 2) == 1;
      c_tag   = TW'($urandom_range(0, 5));
      c_val   = {$urandom, $urandom};
      stall   = ($urandom % 4) == 0;
      flush   = ($urandom % 60) == 0;
      tick();
      n_vec++;
      if (o_rdy !== mv || d_ready !== !model_full()) begin
        n_err++;
        $display("FAIL rnd_ctl_%0d got r%0b dr%0b want r%0b dr%0b",
                 k, o_rdy, d_ready, mv, !model_full());
      end
      if (mv) begin
        n_vec++;
        if (o_v1 !== mv1 || o_v2 !== mv2 || o_tag !== mtag ||
            o_cmd !== mcmd) begin
          n_err++;
          $display("FAIL rnd_data_%0d got %h/%h t%0d c%0d want %h/%h t%0d c%0d",
                   k, o_v1, o_v2, o_tag, o_cmd, mv1, mv2, mtag, mcmd);
        end
      end
    end
    idle_inputs();
    stall = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full_stall();
    test_out_of_order();
    test_flush_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Reservation station feeding the ALU issue/execute stage: holds dispatched ALU micro-ops until both source operands are available, snoops the common data bus (CDB) for missing operands, and issues one ready micro-op per cycle into a registered issue slot. It sits between dispatch/rename and the combinational ALU issue/execute stage, which consumes `reservationStation*_o`/`readyRS_o` and back-pressures through `stallRS_i`.

## Interface
- `ROBsize`, 32, ROB entries; tags are ROB indices
- `ROBsizeLog`, `$clog2(ROBsize+1)`, tag width
- `RSsize`, 4, number of station entries (power of two, ≥2)

Ports:
- `clk_i` in 1: single clock, all state on rising edge
- `reset_i` in 1: asynchronous, active-low reset
- `flush_i` in 1: synchronous squash of all entries and the issue slot
- `dispatchValid_i` in 1: dispatch request this cycle
- `dispatchReady_o` out 1: station can accept a dispatch
- `dispatchCommands_i` in 10: micro-op command bits, passed through unchanged
- `dispatchTag_i` in ROBsizeLog: destination ROB tag
- `dispatchVal1_i` / `dispatchVal2_i` in 64: operand values, meaningful when the matching ready bit is set
- `dispatchRdy1_i` / `dispatchRdy2_i` in 1: operand already available
- `dispatchSrc1_i` / `dispatchSrc2_i` in ROBsizeLog: producer tag when the operand is not ready
- `cdbValid_i` in 1, `cdbTag_i` in ROBsizeLog, `cdbVal_i` in 64: result broadcast
- `reservationStationVal1_o` / `reservationStationVal2_o` out 64: issued operands
- `reservationStationCommands_o` out 10, `reservationStationTag_o` out ROBsizeLog: issued command and tag
- `readyRS_o` out 1: issue slot holds a valid micro-op
- `stallRS_i` in 1: execute stage cannot accept; the issue slot must hold

## Operation
- Each entry: busy, commands, tag, and per operand {rdy, src tag, 64-bit value}.
- Dispatch accepted when `dispatchValid_i & dispatchReady_o`; written into the lowest-index free entry.
- Dispatch-time bypass: if an operand is not ready and `cdbValid_i` with `cdbTag_i == dispatchSrcN_i` in the same cycle, the entry stores `cdbVal_i` with rdy=1.
- Wakeup: every busy entry operand with rdy=0 and a src matching a valid CDB tag captures `cdbVal_i` and sets rdy at the edge. Both operands may wake on one broadcast.
- Eligible entry: busy with both rdy bits set (register state, not the same-cycle CDB).
- Issue slot load condition: `~readyRS_o | ~stallRS_i`. When it holds and an eligible entry exists, the lowest-index eligible entry is copied into the slot and freed; `readyRS_o` is set. When it holds and no eligible entry exists, `readyRS_o` clears.
- While `readyRS_o & stallRS_i`, all slot outputs are held stable; entries keep waking up.
- `dispatchReady_o` = number of busy entries < `RSsize`, from registered state only; an entry freed this cycle is not reusable until the next cycle.
- Flush: at the edge, all busy bits and `readyRS_o` clear; any same-cycle dispatch is dropped.
- Reset (`reset_i` low): all busy bits cleared, `readyRS_o`=0, all data outputs 0, `dispatchReady_o`=1 after release. Reset asserted mid-operation discards all entries immediately.

## Timing
- Dispatch with both operands ready at edge N -> entry busy after N -> slot loaded at edge N+1 -> `readyRS_o`=1 during cycle N+1 (2-edge minimum latency).
- CDB wakeup at edge N -> eligible in cycle N -> issued at edge N+1.
- Back-to-back issue: one micro-op per cycle while `stallRS_i`=0 and eligible entries remain.
- Simultaneous dispatch into the entry being freed is impossible (freed entry is not free until the next cycle); simultaneous dispatch and issue of different entries are both performed.
- Full: with `RSsize` busy entries, `dispatchReady_o`=0; a `dispatchValid_i` pulse is ignored with no state change.

## Test plan
- Reset, then dispatch tag 3, cmd 10, val1 15 rdy, val2 3 rdy -> two edges later `readyRS_o`=1, vals 15/3, tag 3, cmd 10; next cycle `readyRS_o`=0.
- Dispatch tag 5 with src2=7 not ready; CDB tag 7 val 0x55 two cycles later -> issue one edge after the broadcast with val2=0x55; CDB tag 6 causes no wakeup.
- Dispatch with src1=9 while the CDB broadcasts tag 9 val 0xAA in the same cycle -> entry captures 0xAA, issues at the normal 2-edge latency.
- Fill 4 entries while `stallRS_i`=1 -> `dispatchReady_o`=0, fifth dispatch ignored; outputs frozen; release stall -> four issues on consecutive cycles in index order.
- Entries 0 and 1 waiting, entry 1 woken first -> entry 1 issues first; later wake entry 0 -> issues next.
- Flush with 3 busy entries and a valid slot -> next cycle `readyRS_o`=0, `dispatchReady_o`=1; assert `reset_i` low mid-stall -> outputs zero immediately.
